// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory slave for the pipeline's memory stage. Accepts one read or write
// request at a time, services it from an internal word-addressed array after a
// fixed LATENCY, and answers with a one-cycle ready pulse.
//
// Parameters:
//   ADDR_WIDTH : word-address bits; array depth is 2**ADDR_WIDTH 32-bit words
//                (up to 29 bits).
//   LATENCY    : cycles from the request sample edge to the ready pulse (1..15).
//
// Ports:
//   iClk          : clock. All logic runs on the rising edge.
//   iRst_n        : synchronous active-low reset.
//   iDataMemAddr  : byte address. The word index is addr[ADDR_WIDTH+1:2].
//   iDataMemData  : write data.
//   iDataMemRW    : 1 = write, 0 = read.
//   iDataMemValid : request valid. Held stable by the master until ready.
//   oDataMemData  : read data. Valid only while oDataMemReady = 1. Zero for
//                   writes.
//   oDataMemReady : one-cycle completion pulse.
//   oAddrError    : pulses with ready when the request address was illegal.
//   oBusy         : high from the acceptance edge to the end of the ready cycle.
//
// Optional feature macro: DMEM_ADDR_CHECK_EN
//   Defined   : a misaligned address or a nonzero address above the array is
//               illegal. Such a request still completes. It flags oAddrError,
//               writes nothing, and reads back 0.
//   Undefined : the upper and low address bits are ignored (addresses alias),
//               and oAddrError stays 0.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iDataMemAddr,
  input  logic [31:0] iDataMemData,
  input  logic        iDataMemRW,
  input  logic        iDataMemValid,
  output logic [31:0] oDataMemData,
  output logic        oDataMemReady,
  output logic        oAddrError,
  output logic        oBusy
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_rw;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_err;
  logic                  r_busy;

  logic [31:0]           w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic                  w_sel_rw;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_mem_we;
  logic [31:0]           w_rdata_nxt;
  logic                  w_ready_nxt;
  logic                  w_err_nxt;
  logic                  w_busy_nxt;

  assign w_accept = (r_state == S_IDLE) && iDataMemValid;

  // With LATENCY = 1 the acceptance edge is also the RESP entry edge. The
  // captured registers are not loaded yet at that edge, so the request is
  // taken straight from the ports while in IDLE.
  assign w_sel_addr  = (r_state == S_IDLE) ? iDataMemAddr : r_addr;
  assign w_sel_wdata = (r_state == S_IDLE) ? iDataMemData : r_wdata;
  assign w_sel_rw    = (r_state == S_IDLE) ? iDataMemRW   : r_rw;
  assign w_word      = w_sel_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ADDR_CHECK_EN
  assign w_illegal = (w_sel_addr[1:0] != 2'b00) ||
                     (w_sel_addr[31:ADDR_WIDTH+2] != {(30-ADDR_WIDTH){1'b0}});
`else
  // Upper and low address bits are intentionally dropped, so addresses alias.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{w_sel_addr[31:ADDR_WIDTH+2], w_sel_addr[1:0]};
  assign w_illegal          = 1'b0;
`endif

  assign w_enter_resp = (w_next_state == S_RESP) && (r_state != S_RESP);
  // A write whose commit edge coincides with reset is dropped.
  assign w_mem_we     = iRst_n && w_enter_resp && w_sel_rw && !w_illegal;

  // State register.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (iDataMemValid) begin
          w_next_state = (LATENCY > 1) ? S_WAIT : S_RESP;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latency counter: loaded on acceptance and counted down while waiting.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= LAT_LOAD;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Request capture at acceptance. Inputs are ignored until the next IDLE.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rw    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= iDataMemAddr;
      r_wdata <= iDataMemData;
      r_rw    <= iDataMemRW;
    end else begin
      r_addr  <= r_addr;
      r_wdata <= r_wdata;
      r_rw    <= r_rw;
    end
  end

  // Array write port. The contents survive reset.
  always_ff @(posedge iClk) begin
    if (w_mem_we) begin
      r_mem[w_word] <= w_sel_wdata;
    end
  end

  // Output logic: next values of the registered response outputs.
  always_comb begin
    w_rdata_nxt = 32'd0;
    w_ready_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_busy_nxt  = (w_next_state != S_IDLE);
    if (w_enter_resp) begin
      w_ready_nxt = 1'b1;
      w_err_nxt   = w_illegal;
      if (!w_sel_rw && !w_illegal) begin
        w_rdata_nxt = r_mem[w_word];
      end else begin
        w_rdata_nxt = 32'd0;
      end
    end else begin
      w_ready_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = 32'd0;
    end
  end

  // Response output registers. They are cleared by reset and on leaving RESP.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rdata <= w_rdata_nxt;
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign oDataMemData  = r_rdata;
  assign oDataMemReady = r_ready;
  assign oAddrError    = r_err;
  assign oBusy         = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Instance A runs with LATENCY = 2 and
// instance B with LATENCY = 1.
module tb_data_mem_responder;

  localparam int AW    = 10;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;
`ifdef DMEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rw;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic        a_rw, a_valid, a_ready, a_err, a_busy;
  logic        b_rw, b_valid, b_ready, b_err, b_busy;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  vec_t vecs[14];

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_A)) u_dut_a (
    .iClk(clk), .iRst_n(rst_n), .iDataMemAddr(a_addr), .iDataMemData(a_wdata),
    .iDataMemRW(a_rw), .iDataMemValid(a_valid), .oDataMemData(a_rdata),
    .oDataMemReady(a_ready), .oAddrError(a_err), .oBusy(a_busy));

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_B)) u_dut_b (
    .iClk(clk), .iRst_n(rst_n), .iDataMemAddr(b_addr), .iDataMemData(b_wdata),
    .iDataMemRW(b_rw), .iDataMemValid(b_valid), .oDataMemData(b_rdata),
    .oDataMemReady(b_ready), .oAddrError(b_err), .oBusy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard A: every ready pulse pops one expected response.
  always @(negedge clk) begin
    if (a_ready === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL mon_a_unexpected ready=1 data=%h expected ready=0", a_rdata);
      end else begin
        ea = q_a.pop_front();
        if (a_rdata !== ea.data || a_err !== ea.err) begin
          failures++;
          $display("FAIL mon_a data=%h err=%b expected data=%h err=%b", a_rdata, a_err, ea.data, ea.err);
        end
      end
    end
  end

  // Scoreboard B.
  always @(negedge clk) begin
    if (b_ready === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL mon_b_unexpected ready=1 data=%h expected ready=0", b_rdata);
      end else begin
        eb = q_b.pop_front();
        if (b_rdata !== eb.data || b_err !== eb.err) begin
          failures++;
          $display("FAIL mon_b data=%h err=%b expected data=%h err=%b", b_rdata, b_err, eb.data, eb.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] d, input logic rw);
    if (w == 0) begin
      a_valid = v; a_addr = a; a_wdata = d; a_rw = rw;
    end else begin
      b_valid = v; b_addr = a; b_wdata = d; b_rw = rw;
    end
  endtask

  task automatic push(input int w, input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    if (w == 0) q_a.push_back(x);
    else        q_b.push_back(x);
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? a_ready : b_ready;
  endfunction

  // Bounded wait for ready. The pulse must land exactly in cycle c + latency.
  task automatic wait_ready(input int w, input int c, input string name);
    int lat;
    bit got;
    lat = (w == 0) ? LAT_A : LAT_B;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rdy(w) === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout ready never seen, expected at cycle %0d", name, c + lat);
    end else if (cyc != c + lat) begin
      failures++;
      $display("FAIL %s_latency ready cycle=%0d expected=%0d", name, cyc, c + lat);
    end
  endtask

  task automatic req(input int w, input logic [31:0] a, input logic [31:0] d, input logic rw,
                     input logic [31:0] ed, input logic ee, input string name);
    int c;
    @(negedge clk);
    drive(w, 1'b1, a, d, rw);
    push(w, ed, ee);
    c = cyc;
    @(posedge clk);
    #1 drive(w, 1'b0, a, d, rw);
    wait_ready(w, c, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0};
    vecs[1]  = '{32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{32'h0000_0020, 32'hA5A5_5A5A, 1'b1, 32'h0, 1'b0};
    vecs[3]  = '{32'h0000_0FFC, 32'h1234_5678, 1'b1, 32'h0, 1'b0};
    vecs[4]  = '{32'h0000_0020, 32'h0,         1'b0, 32'hA5A5_5A5A, 1'b0};
    vecs[5]  = '{32'h0000_0FFC, 32'h0,         1'b0, 32'h1234_5678, 1'b0};
    vecs[6]  = '{32'h0000_0010, 32'h0BAD_F00D, 1'b1, 32'h0, 1'b0};
    vecs[7]  = '{32'h0000_0010, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b0};
    vecs[8]  = '{32'h0000_0004, 32'h4444_4444, 1'b1, 32'h0, 1'b0};
    vecs[9]  = '{32'h0000_0006, 32'h7777_7777, 1'b1, 32'h0, CHK};
    vecs[10] = '{32'h0000_0004, 32'h0,         1'b0, CHK ? 32'h4444_4444 : 32'h7777_7777, 1'b0};
    vecs[11] = '{32'h0000_0000, 32'h0000_AAAA, 1'b1, 32'h0, 1'b0};
    vecs[12] = '{32'h0001_0000, 32'h0,         1'b0, CHK ? 32'h0 : 32'h0000_AAAA, CHK};
    vecs[13] = '{32'h0000_1010, 32'h0,         1'b0, CHK ? 32'h0 : 32'h0BAD_F00D, CHK};

    // Reset held for three cycles with valid asserted: every output stays 0.
    rst_n = 1'b0;
    drive(0, 1'b1, 32'h40, 32'h1357_9BDF, 1'b1);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_a_out", {a_rdata[31:3], a_ready | a_rdata[2], a_err | a_rdata[1], a_busy | a_rdata[0]}, 32'h0);
      chk("rst_b_out", {b_rdata[31:3], b_ready | b_rdata[2], b_err | b_rdata[1], b_busy | b_rdata[0]}, 32'h0);
    end
    rst_n = 1'b1;
    push(0, 32'h0, 1'b0);
    c = cyc;
    @(posedge clk);
    #1 drive(0, 1'b0, 32'h40, 32'h0, 1'b0);
    wait_ready(0, c, "post_rst");

    // Table-driven transactions on instance A.
    for (int i = 0; i < 14; i++) begin
      req(0, vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Back-to-back on B (LATENCY 1), valid held high across two writes.
    @(negedge clk);
    drive(1, 1'b1, 32'h0, 32'h1111_1111, 1'b1);
    push(1, 32'h0, 1'b0);
    @(negedge clk);
    chk("b2b_ready1", {31'd0, b_ready}, 32'd1);
    drive(1, 1'b1, 32'h4, 32'h2222_2222, 1'b1);
    push(1, 32'h0, 1'b0);
    @(negedge clk);
    chk("b2b_gap", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_ready2", {31'd0, b_ready}, 32'd1);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
    req(1, 32'h0, 32'h0, 1'b0, 32'h1111_1111, 1'b0, "b_rd0");
    req(1, 32'h4, 32'h0, 1'b0, 32'h2222_2222, 1'b0, "b_rd4");

    // Valid dropped in WAIT on A: the request still completes.
    req(0, 32'h4, 32'h2222_2222, 1'b1, 32'h0, 1'b0, "a_wr4");
    @(negedge clk);
    drive(0, 1'b1, 32'h4, 32'h0, 1'b0);
    push(0, 32'h2222_2222, 1'b0);
    @(negedge clk);
    chk("drop_wait_busy", {31'd0, a_busy}, 32'd1);
    chk("drop_wait_ready", {31'd0, a_ready}, 32'd0);
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("drop_resp_ready", {31'd0, a_ready}, 32'd1);
    chk("drop_resp_busy", {31'd0, a_busy}, 32'd1);
    @(negedge clk);
    chk("drop_after_busy", {31'd0, a_busy}, 32'd0);
    chk("drop_after_ready", {31'd0, a_ready}, 32'd0);

    // Reset while A waits on a write: nothing completes and nothing commits.
    req(0, 32'h8, 32'h5A5A_0001, 1'b1, 32'h0, 1'b0, "a_wr8");
    @(negedge clk);
    drive(0, 1'b1, 32'h8, 32'hCAFE_F00D, 1'b1);
    @(negedge clk);
    chk("midrst_busy", {31'd0, a_busy}, 32'd1);
    rst_n = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("midrst_ready", {31'd0, a_ready}, 32'd0);
    chk("midrst_busy_clr", {31'd0, a_busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_ready", {31'd0, a_ready}, 32'd0);
    req(0, 32'h8, 32'h0, 1'b0, 32'h5A5A_0001, 1'b0, "midrst_rd8");

    repeat (3) @(negedge clk);
    chk("q_a_empty", q_a.size(), 32'd0);
    chk("q_b_empty", q_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
